// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divide sequencer for DIV/DIVU, result {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_i (DIV); without it every operation is DIVU.
module div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   oprd1_i,
  input  logic [WIDTH-1:0]   oprd2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2*WIDTH:0] r_work;
  logic [WIDTH-1:0] r_divisor;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_signed_op;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [2*WIDTH:0] w_work_nxt;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  function automatic logic [WIDTH-1:0] f_neg_if(input logic [WIDTH-1:0] v, input logic neg);
    f_neg_if = neg ? (~v + WIDTH'(1)) : v;
  endfunction

`ifdef DIV_SIGNED_EN
  assign w_signed_op = signed_i;
`else
  assign w_signed_op = 1'b0 & signed_i;
`endif

  assign w_mag1     = f_neg_if(oprd1_i, w_signed_op & oprd1_i[WIDTH-1]);
  assign w_mag2     = f_neg_if(oprd2_i, w_signed_op & oprd2_i[WIDTH-1]);
  assign stallreq_o = rst & start_i & ~ready_o & ~annul_i;

  // One restoring step: the partial remainder is WIDTH+1 bits wide, so it is
  // compared against the zero-extended divisor before the WIDTH-bit subtract.
  always_comb begin
    w_ge  = (r_work[2*WIDTH:WIDTH] >= {1'b0, r_divisor});
    w_sub = r_work[2*WIDTH-1:WIDTH] - r_divisor;
    if (w_ge) begin
      w_work_nxt = {w_sub, r_work[WIDTH-1:0], 1'b1};
    end else begin
      w_work_nxt = {r_work[2*WIDTH-1:0], 1'b0};
    end
    w_quo = f_neg_if(w_work_nxt[WIDTH-1:0], r_neg_q);
    w_rem = f_neg_if(w_work_nxt[2*WIDTH:WIDTH+1], r_neg_r);
  end

  // Sequencer FSM, working register and registered result/ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_work    <= {WIDTH'(0), w_mag1, 1'b0};
            r_divisor <= w_mag2;
            r_neg_q   <= w_signed_op & (oprd1_i[WIDTH-1] ^ oprd2_i[WIDTH-1]);
            r_neg_r   <= w_signed_op & oprd1_i[WIDTH-1];
            r_cnt     <= '0;
            r_state   <= (oprd2_i == '0) ? S_DIVZERO : S_ON;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DIVZERO: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            result_o <= '0;
            ready_o  <= 1'b1;
            r_state  <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_work <= w_work_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              result_o <= {w_rem, w_quo};
              ready_o  <= 1'b1;
              r_state  <= S_END;
            end else begin
              r_state <= S_ON;
            end
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_state <= S_END;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vector table, corner sequences, random ops vs model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] oprd1_i;
  logic [31:0] oprd2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .oprd1_i   (oprd1_i),
    .oprd2_i   (oprd2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division; divide by zero yields zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic   use_s;
`ifdef DIV_SIGNED_EN
    use_s = s;
`else
    use_s = 1'b0 & s;
`endif
    if (b == 32'd0) return 64'd0;
    if (use_s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one op (called just after a rising edge), count stall cycles until ready,
  // hold start for 'hold' extra cycles, then drop start for one cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp, input int hold, input string nm);
    int stalls;
    int guard;
    int exp_stalls;
    exp_stalls = (b == 32'd0) ? 2 : 33;
    start_i  = 1'b1;
    annul_i  = 1'b0;
    signed_i = s;
    oprd1_i  = a;
    oprd2_i  = b;
    stalls   = 0;
    guard    = 0;
    #1;
    while (!ready_o && guard < 100) begin
      if (stallreq_o) stalls++;
      @(posedge clk); #1;
      oprd1_i  = $urandom;
      oprd2_i  = $urandom;
      signed_i = ~s;
      #1;
      guard++;
    end
    check({nm, " ready"}, 64'(ready_o), 64'd1);
    check({nm, " stall cycles"}, 64'(stalls), 64'(exp_stalls));
    check({nm, " result"}, result_o, exp);
    check({nm, " stall low at ready"}, 64'(stallreq_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, " held ready"}, 64'(ready_o), 64'd1);
      check({nm, " held result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    check({nm, " ready cleared"}, 64'(ready_o), 64'd0);
    check({nm, " result cleared"}, result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          ready_seen;

    vecs.push_back(vec_t'{32'd100, 32'd7, 1'b0, 32'h0000000E, 32'h00000002});
    vecs.push_back(vec_t'{32'h12345678, 32'd0, 1'b0, 32'h0, 32'h0});
    vecs.push_back(vec_t'{32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'h0});
    vecs.push_back(vec_t'{32'd9, 32'd3, 1'b0, 32'd3, 32'd0});
    vecs.push_back(vec_t'{32'hFFFFFFFE, 32'h80000001, 1'b0, 32'd1, 32'h7FFFFFFD});
    vecs.push_back(vec_t'{32'd5, 32'd9, 1'b0, 32'd0, 32'd5});
    vecs.push_back(vec_t'{32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'h00000001});
`ifdef DIV_SIGNED_EN
    vecs.push_back(vec_t'{32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF});
    vecs.push_back(vec_t'{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h0});
`else
    vecs.push_back(vec_t'{32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'h00000001});
    vecs.push_back(vec_t'{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000});
`endif

    // Reset with start already high: everything quiet, including stall.
    rst = 1'b0; start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0;
    oprd1_i = 32'd100; oprd2_i = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stall", 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle stall", 64'(stallreq_o), 64'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].r, vecs[i].q}, 0, $sformatf("vec%0d", i));
    end

    // Annul during iteration 10: back to IDLE, no result ever appears.
    start_i = 1'b1; oprd1_i = 32'd100; oprd2_i = 32'd7; signed_i = 1'b0;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    #1;
    check("annul stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) ready_seen++;
    end
    check("annul no ready", 64'(ready_seen), 64'd0);
    do_op(32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 0, "after annul");

    // Async reset between edges while a result is held.
    start_i = 1'b1; oprd1_i = 32'd77; oprd2_i = 32'd5;
    for (int i = 0; i < 40 && !ready_o; i++) begin
      @(posedge clk); #1;
    end
    check("pre-reset result", result_o, {32'd2, 32'd15});
    #3;
    rst = 1'b0;
    #1;
    check("async reset ready", 64'(ready_o), 64'd0);
    check("async reset result", result_o, 64'd0);
    check("async reset stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_op(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 0, "post reset");

    // Start held past END: single result, then a new op after one low cycle.
    do_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 5, "hold");
    do_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0, "restart");

    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case (k % 4)
        0:       rb = $urandom_range(1, 255);
        1:       rb = $urandom;
        2:       rb = (k % 8 == 2) ? 32'd0 : ({$urandom} >> $urandom_range(0, 31));
        default: rb = 32'hFFFFFFFF - $urandom_range(0, 3);
      endcase
      do_op(ra, rb, rs, ref_div(ra, rb, rs), k % 3, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
